// File: rtl/lsu_pkg.sv
// Shared load/store types for the posted-store buffer and its helpers.
package lsu_pkg;

  // Storage widths of a buffered entry; store_buffer parameters must not exceed these.
  localparam int LSU_ADDR_W = 20;
  localparam int LSU_DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef struct packed {
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_DATA_W-1:0] data;
    size_e                 size;
  } sb_entry_t;

  // Request size encoding 3 is an alias for a word access.
  function automatic size_e to_size(input logic [1:0] req_size);
    case (req_size)
      2'd0:    return SZ_BYTE;
      2'd1:    return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input size_e sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/sb_load_ext.sv
// Sign/zero extension of raw memory read data for byte, half and word loads.
module sb_load_ext
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] rdata
);

  // Replicate the sign bit of the accessed width unless the load is unsigned.
  always_comb begin
    rdata = raw;
    case (to_size(size))
      SZ_BYTE: rdata = {{(DATA_W-8){~is_unsigned & raw[7]}}, raw[7:0]};
      SZ_HALF: rdata = {{(DATA_W-16){~is_unsigned & raw[15]}}, raw[15:0]};
      default: rdata = raw;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-store FIFO sharing a single memory port with loads; loads win the
// port, stores drain from the head whenever the port is idle, and loads that
// overlap any buffered store stall until that store has drained.
module store_buffer
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int ENTRIES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              empty,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic              mem_one_byte,
  output logic              mem_two_bytes,
  output logic              mem_four_bytes,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PTR_W = $clog2(ENTRIES);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t         fifo [ENTRIES];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              empty_q;

  logic [PTR_W-1:0]  age [ENTRIES];
  logic [ENTRIES-1:0] slot_hit;
  logic [ADDR_W:0]   ld_lo, ld_hi;
  logic              overlap, not_full;
  logic              load_acc, store_acc, drain;
  size_e             req_sz, sel_sz;
  logic [DATA_W-1:0] ext_rdata;

  sb_load_ext #(.DATA_W(DATA_W)) u_ext (
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .raw         (mem_rdata),
    .rdata       (ext_rdata)
  );

  // Compare the load's byte range against every live entry; ranges use one
  // extra address bit so accesses at the top of memory never wrap to zero.
  always_comb begin
    req_sz   = to_size(req_size);
    ld_lo    = {1'b0, req_addr};
    ld_hi    = ld_lo + (ADDR_W+1)'(size_bytes(req_sz));
    slot_hit = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      age[i] = PTR_W'(i) - head;
      slot_hit[i] = ({1'b0, age[i]} < count)
        && (ld_lo < ({1'b0, ADDR_W'(fifo[i].addr)} + (ADDR_W+1)'(size_bytes(fifo[i].size))))
        && ({1'b0, ADDR_W'(fifo[i].addr)} < ld_hi);
    end
    overlap = |slot_hit;
  end

  // Port arbitration: accepted load first, otherwise drain the head entry.
  always_comb begin
    not_full  = (count < CNT_W'(ENTRIES));
    store_acc = ~rst & req_valid & req_wr & not_full;
    load_acc  = ~rst & req_valid & ~req_wr & ~overlap;
    drain     = ~rst & ~load_acc & (count != '0);
    count_nxt = count + CNT_W'(store_acc) - CNT_W'(drain);

    req_ready      = ~rst & (req_wr ? not_full : ~overlap);
    resp_rdata     = '0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_wr         = 1'b0;
    mem_rd         = 1'b0;
    mem_one_byte   = 1'b0;
    mem_two_bytes  = 1'b0;
    mem_four_bytes = 1'b0;
    sel_sz         = req_sz;

    if (load_acc) begin
      mem_rd     = 1'b1;
      mem_addr   = req_addr;
      resp_rdata = ext_rdata;
    end else if (drain) begin
      mem_wr    = 1'b1;
      mem_addr  = ADDR_W'(fifo[head].addr);
      mem_wdata = DATA_W'(fifo[head].data);
      sel_sz    = fifo[head].size;
    end

    if (load_acc | drain) begin
      mem_one_byte   = (sel_sz == SZ_BYTE);
      mem_two_bytes  = (sel_sz == SZ_HALF);
      mem_four_bytes = (sel_sz == SZ_WORD);
    end

    empty = rst | empty_q;
  end

  // Pointer and occupancy bookkeeping; reset discards every buffered store.
  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      empty_q <= 1'b1;
    end else begin
      if (store_acc) tail <= tail + PTR_W'(1);
      if (drain)     head <= head + PTR_W'(1);
      count   <= count_nxt;
      empty_q <= (count_nxt == '0);
    end
  end

  // Entry payload is written unmasked; its size decides which bytes drain.
  always_ff @(posedge clk) begin
    if (store_acc)
      fifo[tail] <= '{addr: LSU_ADDR_W'(req_addr),
                      data: LSU_DATA_W'(req_wdata),
                      size: req_sz};
  end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized bench for store_buffer against a queue-based store model and a
// byte-array memory image.
module tb_store_buffer;

  localparam int ENTRIES = 4;
  localparam int MEM_SZ  = 1 << 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_wr, req_unsigned;
  logic [1:0]  req_size;
  logic [19:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready, empty;
  logic [31:0] resp_rdata, mem_wdata, mem_rdata;
  logic [19:0] mem_addr;
  logic        mem_wr, mem_rd, mem_one_byte, mem_two_bytes, mem_four_bytes;

  logic [7:0] mem     [MEM_SZ];
  logic [7:0] ref_mem [MEM_SZ];

  typedef struct {
    logic [19:0] addr;
    logic [1:0]  sz;
    logic [31:0] data;
  } st_t;
  st_t q[$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  store_buffer #(.ADDR_W(20), .DATA_W(32), .ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_rdata(resp_rdata), .empty(empty),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_one_byte(mem_one_byte), .mem_two_bytes(mem_two_bytes),
    .mem_four_bytes(mem_four_bytes), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = {mem[mem_addr + 20'd3], mem[mem_addr + 20'd2],
                      mem[mem_addr + 20'd1], mem[mem_addr]};

  always @(negedge clk) begin
    if (mem_wr) begin
      mem[mem_addr] <= mem_wdata[7:0];
      if (mem_two_bytes || mem_four_bytes) mem[mem_addr + 20'd1] <= mem_wdata[15:8];
      if (mem_four_bytes) begin
        mem[mem_addr + 20'd2] <= mem_wdata[23:16];
        mem[mem_addr + 20'd3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] size_mask(input logic [1:0] sz);
    return (sz == 2'd0) ? 32'h0000_00FF : (sz == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ref_load(input logic [19:0] a, input logic [1:0] sz, input logic uns);
    logic [31:0] raw;
    logic [7:0]  b;
    logic [15:0] h;
    raw = {ref_mem[a + 20'd3], ref_mem[a + 20'd2], ref_mem[a + 20'd1], ref_mem[a]};
    b = raw[7:0];
    h = raw[15:0];
    if (sz == 2'd0) return uns ? {24'd0, b} : 32'($signed(b));
    if (sz == 2'd1) return uns ? {16'd0, h} : 32'($signed(h));
    return raw;
  endfunction

  // One request cycle: compare against the model, advance the clock, update the model.
  task automatic step(input logic v, input logic w, input logic [1:0] sz, input logic uns,
                      input logic [19:0] a, input logic [31:0] d);
    longint lo, hi, elo, ehi;
    bit ov, exp_ready, ld_acc, st_acc, exp_wr;
    logic [1:0] wsz;
    st_t e;
    req_valid = v; req_wr = w; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = d;
    #2;
    lo = longint'(a);
    hi = lo + nbytes(sz);
    ov = 0;
    foreach (q[i]) begin
      elo = longint'(q[i].addr);
      ehi = elo + nbytes(q[i].sz);
      if (lo < ehi && elo < hi) ov = 1;
    end
    exp_ready = w ? (q.size() < ENTRIES) : !ov;
    ld_acc = v && !w && !ov;
    st_acc = v && w && (q.size() < ENTRIES);
    exp_wr = !ld_acc && (q.size() > 0);
    check("empty", {31'd0, empty}, {31'd0, q.size() == 0});
    check("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
    check("mem_rd", {31'd0, mem_rd}, {31'd0, ld_acc});
    check("mem_wr", {31'd0, mem_wr}, {31'd0, exp_wr});
    wsz = ld_acc ? sz : (exp_wr ? q[0].sz : 2'd0);
    if (ld_acc) begin
      check("ld_addr", {12'd0, mem_addr}, {12'd0, a});
      check("resp_rdata", resp_rdata, ref_load(a, sz, uns));
    end else if (exp_wr) begin
      check("wr_addr", {12'd0, mem_addr}, {12'd0, q[0].addr});
      check("wr_data", mem_wdata & size_mask(q[0].sz), q[0].data & size_mask(q[0].sz));
    end
    if (ld_acc || exp_wr)
      check("strobes", {29'd0, mem_one_byte, mem_two_bytes, mem_four_bytes},
            {29'd0, nbytes(wsz) == 1, nbytes(wsz) == 2, nbytes(wsz) == 4});
    @(posedge clk);
    #1;
    if (exp_wr) begin
      e = q.pop_front();
      for (int k = 0; k < nbytes(e.sz); k++)
        ref_mem[e.addr + 20'(k)] = e.data[8*k +: 8];
    end
    if (st_acc) begin
      e.addr = a; e.sz = sz; e.data = d;
      q.push_back(e);
    end
  endtask

  task automatic do_reset(input logic v, input logic w);
    rst = 1'b1;
    req_valid = v; req_wr = w; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 20'h100; req_wdata = 32'h1234_5678;
    #2;
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_strobes", {29'd0, mem_one_byte, mem_two_bytes, mem_four_bytes}, 32'd0);
    check("rst_mem_addr", {12'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    @(posedge clk);
    #1;
    q.delete();
    rst = 1'b0;
  endtask

  function automatic logic [19:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return 20'h100 + 20'($urandom_range(0, 15));
    if (r < 8) return 20'hFFFF8 + 20'($urandom_range(0, 7));
    return 20'($urandom);
  endfunction

  initial begin
    for (int i = 0; i < MEM_SZ; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    @(posedge clk);
    #1;
    do_reset(1'b0, 1'b0);

    step(1, 1, 2'd2, 0, 20'h100, 32'hDEAD_BEEF);
    step(0, 0, 2'd0, 0, 20'h0, 32'h0);
    step(0, 0, 2'd0, 0, 20'h0, 32'h0);

    for (int i = 0; i < 5; i++) begin
      step(1, 1, 2'd2, 0, 20'h300 + 20'(4*i), 32'hA000_0000 + 32'(i));
      step(1, 0, 2'd2, 0, 20'h800, 32'h0);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 2'd0, 0, 20'h0, 32'h0);

    step(1, 1, 2'd0, 0, 20'h203, 32'h0000_0080);
    step(1, 0, 2'd1, 0, 20'h202, 32'h0);
    step(1, 0, 2'd1, 0, 20'h202, 32'h0);
    step(1, 0, 2'd1, 1, 20'h202, 32'h0);

    step(1, 1, 2'd1, 0, 20'h010, 32'h0000_BEEF);
    step(1, 0, 2'd2, 0, 20'h012, 32'h0);
    step(0, 0, 2'd0, 0, 20'h0, 32'h0);

    step(1, 1, 2'd3, 0, 20'hFFFFE, 32'h1122_3344);
    step(1, 0, 2'd0, 1, 20'h00000, 32'h0);
    step(1, 1, 2'd2, 0, 20'h400, 32'h5555_AAAA);
    do_reset(1'b1, 1'b1);
    step(1, 0, 2'd2, 0, 20'h400, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0)
        do_reset(1'($urandom), 1'($urandom));
      else
        step($urandom_range(0, 9) < 8, 1'($urandom), 2'($urandom), 1'($urandom),
             rand_addr(), $urandom);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 2'd0, 0, 20'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
